mpsoc_ahb3_spram_ws: RTL and testbench
======================================

# mpsoc_ahb3_spram_ws

AHB3-Lite single-port SRAM slave, successor to the fixed zero-wait SRAM slave: parametrised read wait states, byte-lane write forwarding instead of contention stalls, and protocol-correct two-cycle ERROR responses for out-of-range or misaligned transfers. Sits on an AHB3 interconnect slave port as on-chip data/instruction memory. The memory array is inferred internally with byte enables and has no reset.

## Interface
- MEM_SIZE, 0: memory size in bytes; 0 means MEM_DEPTH governs.
- MEM_DEPTH, 256: minimum depth in HDATA_SIZE words. REAL_DEPTH = max(MEM_DEPTH, 8*MEM_SIZE/HDATA_SIZE), rounded up to a power of two.
- HADDR_SIZE, 32: address width.
- HDATA_SIZE, 32: data width; one of 8/16/32/64/128. BE_SIZE = HDATA_SIZE/8.
- READ_WAIT, 0: read wait states, 0..7.
- HCLK  in  1  clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  HADDR_SIZE  byte address.
- HWDATA  in  HDATA_SIZE  write data, data phase.
- HRDATA  out  HDATA_SIZE  read data.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size, log2 bytes.
- HBURST  in  3  ignored; every beat is decoded independently.
- HPROT  in  4  ignored.
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ.
- HMASTLOCK  in  1  ignored.
- HREADYOUT  out  1  slave ready.
- HREADY  in  1  bus ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

## Operation
- Accept an address phase when HSEL & HREADY & HTRANS is NONSEQ or SEQ. Otherwise the next data phase is zero-wait OKAY.
- Error check on the accepted phase, with offset = HADDR[log2(BE_SIZE)-1:0]:
  - ERROR if HADDR >= REAL_DEPTH*BE_SIZE.
  - ERROR if HSIZE > log2(BE_SIZE).
  - ERROR if HADDR is not aligned to 2^HSIZE.
- Byte enables: ((1<<2^HSIZE)-1) << offset.
- FSM states: S_IDLE, S_WRITE, S_READ, S_ERR1, S_ERR2. Next state is evaluated only when the current data phase completes, or from S_IDLE.
  - Accepted write -> S_WRITE.
  - Accepted read, READ_WAIT = 0 -> S_IDLE (data is returned in that cycle).
  - Accepted read, READ_WAIT > 0 -> S_READ.
  - Error -> S_ERR1.
- S_WRITE:
  - HREADYOUT = 1.
  - Latch HWDATA, BE and word address into the pending-write register.
  - Commit to the array at the end of the cycle. No stall under any contention.
- S_READ:
  - Wait counter loaded with READ_WAIT.
  - HREADYOUT = 0 while counter != 0; decrement each cycle.
  - HREADYOUT = 1 with valid HRDATA when the counter reaches 0.
- S_ERR1: HRESP = 1, HREADYOUT = 0, then go to S_ERR2.
- S_ERR2: HRESP = 1, HREADYOUT = 1, then accept the next phase. The array is never written on ERROR.
- Forwarding: if a read is accepted in the same cycle that a pending write commits to the same word, returned HRDATA lanes with BE set take the write data; other lanes take array data.
- HRDATA holds its last value when no read data phase is active.

## Timing
- Reset values:
  - HREADYOUT = 1.
  - HRESP = 0.
  - HRDATA = 0.
  - FSM = S_IDLE.
  - Wait counter = 0.
  - Pending write cleared.
- A write data phase in progress when HRESET is asserted is discarded, not committed.
- Reset during S_READ or S_ERR1 aborts; HREADYOUT = 1 the cycle after the reset edge.
- Read latency from address-phase edge to data is READ_WAIT+1 cycles. With READ_WAIT = 0 the data phase completes in one cycle.
- Write latency: zero wait; the array is updated at the end of the data phase.
- Back-to-back write(A)->read(A) returns the new bytes with no bubble and HREADYOUT held 1.
- Write->read of a different word: no interaction.
- With HREADY low because another slave is stalling, no phase is accepted, even if HSEL is set.
- During BUSY the FSM does not advance and the response is zero-wait OKAY.
- ERROR is always exactly two cycles; the first cycle has HREADYOUT = 0.
- Last byte boundary: address REAL_DEPTH*BE_SIZE-1 with HSIZE = 0 is legal; REAL_DEPTH*BE_SIZE is ERROR.

## Test plan
- Reset, then idle: HREADYOUT = 1, HRESP = 0, HRDATA = 0 after 3 idle cycles.
- READ_WAIT = 0:
  - Word write 0xDEADBEEF @0x10, next-cycle word read @0x10 -> HRDATA = 0xDEADBEEF, HREADYOUT never low.
  - Byte write 0xAA @0x11, then word read @0x10 -> 0xDEADAAEF via forwarding.
- READ_WAIT = 3: read @0x20 -> HREADYOUT low for exactly 3 cycles, data valid on the 4th. HREADY low from a foreign slave for 2 cycles -> no phase accepted.
- Out of range and misaligned:
  - Read @0x400 (1 KiB memory) -> HRESP = 1 for 2 cycles, HREADYOUT 0 then 1.
  - Halfword write @0x13 -> ERROR, memory @0x10 unchanged on read-back.
- Reset mid-operation: HRESET asserted in the S_WRITE cycle of a write of 0x12345678 @0x30 -> read-back returns the prior value. HRESET in S_READ -> HREADYOUT = 1 the next cycle.

Source files
------------

// File: rtl/mpsoc_ahb3_spram_ws_if.sv
// ---------------------------------------------------------------------------
// mpsoc_ahb3_spram_ws_if
//   AHB3-Lite slave-port bundle for the wait-state SRAM slave.
//   master modport : drives HSEL/HADDR/HWDATA/HWRITE/HSIZE/HBURST/HPROT/
//                    HTRANS/HMASTLOCK and the bus-wide HREADY; receives
//                    HRDATA/HREADYOUT/HRESP.
//   slave modport  : the mirror image, used by mpsoc_ahb3_spram_ws.
// ---------------------------------------------------------------------------
interface mpsoc_ahb3_spram_ws_if #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
);
    logic                  HSEL;
    logic [HADDR_SIZE-1:0] HADDR;
    logic [HDATA_SIZE-1:0] HWDATA;
    logic [HDATA_SIZE-1:0] HRDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HMASTLOCK;
    logic                  HREADYOUT;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
               HMASTLOCK, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
               HMASTLOCK, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/mpsoc_ahb3_spram_ws.sv
// ---------------------------------------------------------------------------
// mpsoc_ahb3_spram_ws
//   AHB3-Lite single-port SRAM slave with READ_WAIT read wait states,
//   zero-wait writes with read-after-write byte-lane forwarding, and
//   two-cycle ERROR responses for out-of-range / oversize / misaligned
//   transfers.
//   Ports:
//     HCLK_i   - clock, all logic on the rising edge
//     HRESET_i - synchronous active-high reset
//     ahb      - AHB3-Lite slave port (mpsoc_ahb3_spram_ws_if.slave)
// ---------------------------------------------------------------------------
module mpsoc_ahb3_spram_ws #(
    parameter int MEM_SIZE   = 0,
    parameter int MEM_DEPTH  = 256,
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int READ_WAIT  = 0
) (
    input  logic                   HCLK_i,
    input  logic                   HRESET_i,
    mpsoc_ahb3_spram_ws_if.slave   ahb
);
    localparam int BE_SIZE    = HDATA_SIZE / 8;
    localparam int OFF_BITS   = $clog2(BE_SIZE);
    localparam int OFFW       = (OFF_BITS == 0) ? 1 : OFF_BITS;
    localparam int SIZE_DEPTH = 8 * MEM_SIZE / HDATA_SIZE;
    localparam int MIN_DEPTH  = (MEM_DEPTH > SIZE_DEPTH) ? MEM_DEPTH : SIZE_DEPTH;
    localparam int ADDR_BITS  = (MIN_DEPTH < 2) ? 1 : $clog2(MIN_DEPTH);
    localparam int REAL_DEPTH = 1 << ADDR_BITS;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_ERR1, S_ERR2} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
    logic [BE_SIZE-1:0]     wr_be_q, wr_be_d;
    logic [ADDR_BITS-1:0]   rd_addr_q, rd_addr_d;
    logic [HDATA_SIZE-1:0]  hrdata_q;
    logic [HDATA_SIZE-1:0]  mem_array [REAL_DEPTH];

    // ---------------- address-phase decode ----------------
    logic                  accept, phase_done;
    logic                  addr_err, size_err, align_err, xfer_err;
    logic [OFFW-1:0]       offset;
    logic [7:0]            size_mask;
    logic [31:0]           lane_mask;
    logic [BE_SIZE-1:0]    be;
    logic [ADDR_BITS-1:0]  word_addr;
    logic                  hready_out, hresp_out;

    assign accept    = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
    assign offset    = (OFF_BITS == 0) ? '0 : ahb.HADDR[OFFW-1:0];
    assign word_addr = ahb.HADDR[OFF_BITS +: ADDR_BITS];
    // Any set bit above the array's byte span means out of range.
    assign addr_err  = (ahb.HADDR >> (OFF_BITS + ADDR_BITS)) != '0;
    assign size_err  = ahb.HSIZE > 3'(OFF_BITS);
    assign size_mask = (8'd1 << ahb.HSIZE) - 8'd1;
    assign align_err = (offset & size_mask[OFFW-1:0]) != '0;
    assign xfer_err  = addr_err | size_err | align_err;
    // 2^HSIZE ones, shifted to the byte offset within the word.
    assign lane_mask = (32'd1 << (6'd1 << ahb.HSIZE)) - 32'd1;
    assign be        = lane_mask[BE_SIZE-1:0] << offset;

    // ---------------- FSM next state / outputs ----------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_addr_d  = wr_addr_q;
        wr_be_d    = wr_be_q;
        rd_addr_d  = rd_addr_q;
        phase_done = 1'b0;
        hready_out = 1'b1;
        hresp_out  = 1'b0;
        case (state_q)
            S_IDLE, S_WRITE: phase_done = 1'b1;
            S_READ: begin
                if (cnt_q == 3'd0) begin
                    phase_done = 1'b1;
                end else begin
                    hready_out = 1'b0;
                    cnt_d      = cnt_q - 3'd1;
                end
            end
            S_ERR1: begin
                hready_out = 1'b0;
                hresp_out  = 1'b1;
                state_d    = S_ERR2;
            end
            S_ERR2: begin
                hresp_out  = 1'b1;
                phase_done = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // A new transfer is only decoded once the current data phase ends.
        if (phase_done) begin
            state_d = S_IDLE;
            if (accept) begin
                if (xfer_err) begin
                    state_d = S_ERR1;
                end else if (ahb.HWRITE) begin
                    state_d   = S_WRITE;
                    wr_addr_d = word_addr;
                    wr_be_d   = be;
                end else begin
                    rd_addr_d = word_addr;
                    if (READ_WAIT != 0) begin
                        state_d = S_READ;
                        cnt_d   = 3'(READ_WAIT);
                    end
                end
            end
        end
    end

    // ---------------- array access ----------------
    logic                   wr_commit, rd_accept, rd_late, fwd;
    logic [ADDR_BITS-1:0]   rd_addr;
    logic [HDATA_SIZE-1:0]  rd_merged;

    // The write data phase commits on its closing edge unless reset hits it.
    assign wr_commit = (state_q == S_WRITE) & ~HRESET_i;
    // Zero-wait reads sample the array on the address edge; waited reads
    // sample it on the edge that ends the last wait cycle.
    assign rd_accept = phase_done & accept & ~xfer_err & ~ahb.HWRITE & (READ_WAIT == 0);
    assign rd_late   = (state_q == S_READ) & (cnt_q == 3'd1);
    assign rd_addr   = rd_late ? rd_addr_q : word_addr;
    // A read hitting the word being committed on the same edge sees the
    // new bytes in the written lanes.
    assign fwd       = wr_commit & (wr_addr_q == rd_addr);

    genvar gi;
    generate
        for (gi = 0; gi < BE_SIZE; gi++) begin : g_lane
            assign rd_merged[gi*8 +: 8] = (fwd && wr_be_q[gi]) ? ahb.HWDATA[gi*8 +: 8]
                                                               : mem_array[rd_addr][gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge HCLK_i) begin
        if (wr_commit) begin
            for (int i = 0; i < BE_SIZE; i++) begin
                if (wr_be_q[i]) mem_array[wr_addr_q][i*8 +: 8] <= ahb.HWDATA[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge HCLK_i) begin
        if (HRESET_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            wr_addr_q <= '0;
            wr_be_q   <= '0;
            rd_addr_q <= '0;
            hrdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_addr_q <= wr_addr_d;
            wr_be_q   <= wr_be_d;
            rd_addr_q <= rd_addr_d;
            if (rd_accept || rd_late) hrdata_q <= rd_merged;
        end
    end

    assign ahb.HREADYOUT = hready_out;
    assign ahb.HRESP     = hresp_out;
    assign ahb.HRDATA    = hrdata_q;

    logic unused_bits;
    assign unused_bits = ^{ahb.HBURST, ahb.HPROT, ahb.HMASTLOCK, ahb.HTRANS[0],
                           lane_mask, size_mask};
endmodule

// File: tb/tb_mpsoc_ahb3_spram_ws.sv
// Two SRAM slaves on one AHB bus: dut0 with zero read wait states and dut1
// with three. Both are 1 KiB (default 256 x 32-bit words).
module tb_mpsoc_ahb3_spram_ws;
    localparam int RW1 = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        hsel = 1'b0, dsel = 1'b0, hwrite = 1'b0, stall_ext = 1'b0;
    logic [31:0] haddr = '0, hwdata = '0;
    logic [2:0]  hsize = '0;
    logic [1:0]  htrans = '0;
    logic        hready_bus, hreadyout_sel, hresp_sel;
    logic [31:0] hrdata_sel;

    mpsoc_ahb3_spram_ws_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus0 ();
    mpsoc_ahb3_spram_ws_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus1 ();

    assign bus0.HSEL = hsel & ~dsel;     assign bus1.HSEL = hsel & dsel;
    assign bus0.HADDR = haddr;           assign bus1.HADDR = haddr;
    assign bus0.HWDATA = hwdata;         assign bus1.HWDATA = hwdata;
    assign bus0.HWRITE = hwrite;         assign bus1.HWRITE = hwrite;
    assign bus0.HSIZE = hsize;           assign bus1.HSIZE = hsize;
    assign bus0.HBURST = 3'd0;           assign bus1.HBURST = 3'd0;
    assign bus0.HPROT = 4'd0;            assign bus1.HPROT = 4'd0;
    assign bus0.HTRANS = htrans;         assign bus1.HTRANS = htrans;
    assign bus0.HMASTLOCK = 1'b0;        assign bus1.HMASTLOCK = 1'b0;
    assign bus0.HREADY = hready_bus;     assign bus1.HREADY = hready_bus;

    assign hreadyout_sel = dsel ? bus1.HREADYOUT : bus0.HREADYOUT;
    assign hresp_sel     = dsel ? bus1.HRESP     : bus0.HRESP;
    assign hrdata_sel    = dsel ? bus1.HRDATA    : bus0.HRDATA;
    assign hready_bus    = ~stall_ext & hreadyout_sel;

    mpsoc_ahb3_spram_ws #(.READ_WAIT(0)) u_dut0 (.HCLK_i(clk), .HRESET_i(rst), .ahb(bus0));
    mpsoc_ahb3_spram_ws #(.READ_WAIT(RW1)) u_dut1 (.HCLK_i(clk), .HRESET_i(rst), .ahb(bus1));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single non-pipelined transfer; counts wait cycles and HRESP cycles.
    task automatic xfer(input bit d, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output int resp_cnt, output int waits);
        dsel = d; hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
        tick();
        hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
        waits = 0; resp_cnt = 0;
        while (hready_bus !== 1'b1 && waits < 20) begin
            if (hresp_sel === 1'b1) resp_cnt++;
            waits++;
            tick();
        end
        if (hresp_sel === 1'b1) resp_cnt++;
        rdata = hrdata_sel;
        tick();
        $display("xfer dut%0d %s addr=0x%08h size=%0d wdata=0x%08h rdata=0x%08h resp_cycles=%0d waits=%0d",
                 d, wr ? "WR" : "RD", addr, size, wdata, rdata, resp_cnt, waits);
    endtask

    // Write address phase followed immediately by a read address phase
    // (read issued during the write data phase), on dut0.
    task automatic pipe_wr_rd(input logic [31:0] waddr, input logic [2:0] wsize,
                              input logic [31:0] wdata, input logic [31:0] raddr,
                              input logic [31:0] exp);
        dsel = 1'b0; hsel = 1'b1; htrans = 2'b10; haddr = waddr; hwrite = 1'b1; hsize = wsize;
        tick();
        check("pipe_wr_ready", hready_bus, 1);
        hwdata = wdata; haddr = raddr; hwrite = 1'b0; hsize = 3'd2;
        tick();
        hsel = 1'b0; htrans = 2'b00;
        check("pipe_rd_ready", hreadyout_sel, 1);
        check("pipe_rd_data", hrdata_sel, exp);
        $display("pipe dut0 WR addr=0x%08h data=0x%08h then RD addr=0x%08h rdata=0x%08h",
                 waddr, wdata, raddr, hrdata_sel);
        tick();
    endtask

    typedef struct {
        bit          d;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          exp_resp;
        int          exp_waits;
        bit          chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    function automatic vec_t mk(bit d, bit wr, logic [31:0] addr, logic [2:0] size,
                                logic [31:0] wdata, int exp_resp, int exp_waits,
                                bit chk_rd, logic [31:0] exp_rd);
        vec_t v;
        v.d = d; v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata;
        v.exp_resp = exp_resp; v.exp_waits = exp_waits; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
        return v;
    endfunction

    // Reference model: byte-addressed memory per slave.
    logic [7:0] model [2][1024];

    task automatic model_xfer(input bit d, input bit wr, input logic [31:0] addr,
                              input logic [2:0] size, input logic [31:0] wdata,
                              output int exp_resp, output int exp_waits,
                              output bit is_rd, output logic [31:0] exp_rd);
        int  nbytes;
        bit  err;
        int  base;
        nbytes = 1 << size;
        err = (addr >= 32'd1024) || (size > 3'd2) || ((addr % nbytes) != 0);
        is_rd = 1'b0; exp_rd = '0;
        if (err) begin
            exp_resp = 2; exp_waits = 1;
        end else if (wr) begin
            exp_resp = 0; exp_waits = 0;
            for (int b = 0; b < nbytes; b++) begin
                int a;
                a = int'(addr) + b;
                model[d][a] = wdata[8*(a%4) +: 8];
            end
        end else begin
            exp_resp = 0; exp_waits = d ? RW1 : 0;
            is_rd = 1'b1;
            base = int'(addr) & ~3;
            exp_rd = {model[d][base+3], model[d][base+2], model[d][base+1], model[d][base]};
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        logic [31:0] rd;
        int          rc, wt;
        logic [31:0] last_rd [2];
        bit          last_ok [2];

        // ---------------- reset ----------------
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        check("rst_hreadyout0", bus0.HREADYOUT, 1);
        check("rst_hresp0",     bus0.HRESP,     0);
        check("rst_hrdata0",    bus0.HRDATA,    0);
        check("rst_hreadyout1", bus1.HREADYOUT, 1);
        check("rst_hresp1",     bus1.HRESP,     0);
        check("rst_hrdata1",    bus1.HRDATA,    0);

        // ---------------- table-driven vectors ----------------
        vecs.push_back(mk(0, 1, 32'h010, 2, 32'hDEADBEEF, 0, 0, 0, '0));
        vecs.push_back(mk(0, 0, 32'h010, 2, 32'h0,        0, 0, 1, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 32'h011, 0, 32'h0000AA00, 0, 0, 0, '0));
        vecs.push_back(mk(0, 0, 32'h010, 2, 32'h0,        0, 0, 1, 32'hDEADAAEF));
        vecs.push_back(mk(0, 0, 32'h400, 2, 32'h0,        2, 1, 0, '0));
        vecs.push_back(mk(0, 1, 32'h013, 1, 32'h55660000, 2, 1, 0, '0));
        vecs.push_back(mk(0, 0, 32'h010, 2, 32'h0,        0, 0, 1, 32'hDEADAAEF));
        vecs.push_back(mk(0, 0, 32'h010, 3, 32'h0,        2, 1, 0, '0));
        vecs.push_back(mk(0, 1, 32'h3FC, 2, 32'h01020304, 0, 0, 0, '0));
        vecs.push_back(mk(0, 1, 32'h3FF, 0, 32'h5A000000, 0, 0, 0, '0));
        vecs.push_back(mk(0, 0, 32'h3FC, 2, 32'h0,        0, 0, 1, 32'h5A020304));
        vecs.push_back(mk(0, 0, 32'h3FF, 0, 32'h0,        0, 0, 1, 32'h5A020304));
        vecs.push_back(mk(0, 1, 32'h400, 0, 32'h000000EE, 2, 1, 0, '0));
        vecs.push_back(mk(0, 1, 32'h012, 1, 32'h77880000, 0, 0, 0, '0));
        vecs.push_back(mk(0, 0, 32'h010, 2, 32'h0,        0, 0, 1, 32'h7788AAEF));
        vecs.push_back(mk(0, 1, 32'h011, 1, 32'h0000CC00, 2, 1, 0, '0));
        vecs.push_back(mk(1, 1, 32'h020, 2, 32'hCAFEF00D, 0, 0, 0, '0));
        vecs.push_back(mk(1, 0, 32'h020, 2, 32'h0,        0, 3, 1, 32'hCAFEF00D));
        vecs.push_back(mk(1, 1, 32'h022, 1, 32'hBEEF0000, 0, 0, 0, '0));
        vecs.push_back(mk(1, 0, 32'h020, 2, 32'h0,        0, 3, 1, 32'hBEEFF00D));
        vecs.push_back(mk(1, 0, 32'h400, 2, 32'h0,        2, 1, 0, '0));
        vecs.push_back(mk(1, 0, 32'h021, 1, 32'h0,        2, 1, 0, '0));
        vecs.push_back(mk(1, 0, 32'h023, 0, 32'h0,        0, 3, 1, 32'hBEEFF00D));

        for (int i = 0; i < vecs.size(); i++) begin
            xfer(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, rd, rc, wt);
            check($sformatf("vec%0d_resp", i), rc, vecs[i].exp_resp);
            check($sformatf("vec%0d_waits", i), wt, vecs[i].exp_waits);
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
        end

        // ---------------- back-to-back write -> read ----------------
        pipe_wr_rd(32'h050, 3'd2, 32'hDEADBEEF, 32'h050, 32'hDEADBEEF);
        pipe_wr_rd(32'h051, 3'd0, 32'h0000AA00, 32'h050, 32'hDEADAAEF);
        pipe_wr_rd(32'h058, 3'd2, 32'h11111111, 32'h050, 32'hDEADAAEF);
        xfer(0, 0, 32'h058, 3'd2, 32'h0, rd, rc, wt);
        check("diff_word_rdata", rd, 32'h11111111);

        // ---------------- foreign stall: HREADY low, HSEL set ----------------
        dsel = 1'b1; stall_ext = 1'b1; hsel = 1'b1; htrans = 2'b10;
        haddr = 32'h400; hwrite = 1'b0; hsize = 3'd2;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 1) begin
                hsel = 1'b0; htrans = 2'b00; stall_ext = 1'b0;
            end
            check($sformatf("stall%0d_hreadyout", i), bus1.HREADYOUT, 1);
            check($sformatf("stall%0d_hresp", i), bus1.HRESP, 0);
        end
        $display("stall dut1 HREADY low 2 cycles with HSEL, hreadyout=%0d hresp=%0d",
                 bus1.HREADYOUT, bus1.HRESP);

        // ---------------- BUSY ----------------
        dsel = 1'b1; hsel = 1'b1; htrans = 2'b01; haddr = 32'h400;
        tick();
        check("busy_hreadyout", bus1.HREADYOUT, 1);
        check("busy_hresp", bus1.HRESP, 0);
        hsel = 1'b0; htrans = 2'b00;
        tick();
        check("busy_after_hreadyout", bus1.HREADYOUT, 1);
        $display("busy dut1 addr=0x400 hreadyout=%0d hresp=%0d", bus1.HREADYOUT, bus1.HRESP);

        // ---------------- reset during write data phase ----------------
        xfer(0, 1, 32'h030, 3'd2, 32'h0BADF00D, rd, rc, wt);
        dsel = 1'b0; hsel = 1'b1; htrans = 2'b10; haddr = 32'h030; hwrite = 1'b1; hsize = 3'd2;
        tick();
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h12345678; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstwr_hrdata", hrdata_sel, 0);
        check("rstwr_hreadyout", hreadyout_sel, 1);
        $display("reset dut0 during write of 0x12345678 @0x30");
        xfer(0, 0, 32'h030, 3'd2, 32'h0, rd, rc, wt);
        check("rstwr_readback", rd, 32'h0BADF00D);

        // ---------------- reset during S_READ ----------------
        dsel = 1'b1; hsel = 1'b1; htrans = 2'b10; haddr = 32'h020; hwrite = 1'b0; hsize = 3'd2;
        tick();
        hsel = 1'b0; htrans = 2'b00;
        check("rstrd_wait", hreadyout_sel, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstrd_hreadyout", bus1.HREADYOUT, 1);
        check("rstrd_hrdata", bus1.HRDATA, 0);
        $display("reset dut1 during read wait, hreadyout=%0d", bus1.HREADYOUT);
        tick();

        // ---------------- reset during S_ERR1 ----------------
        dsel = 1'b0; hsel = 1'b1; htrans = 2'b10; haddr = 32'h400; hwrite = 1'b0; hsize = 3'd2;
        tick();
        hsel = 1'b0; htrans = 2'b00;
        check("rsterr_hresp", hresp_sel, 1);
        check("rsterr_hready", hreadyout_sel, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rsterr_after_hreadyout", hreadyout_sel, 1);
        check("rsterr_after_hresp", hresp_sel, 0);
        $display("reset dut0 during error first cycle, hreadyout=%0d hresp=%0d",
                 hreadyout_sel, hresp_sel);
        tick();

        // ---------------- randomized against the model ----------------
        for (int d = 0; d < 2; d++) begin
            last_ok[d] = 1'b0;
            last_rd[d] = '0;
            for (int w = 0; w < 16; w++) begin
                logic [31:0] a, wd;
                int er, ew; bit ir; logic [31:0] erd;
                a = 32'h100 + 32'(w * 4);
                wd = $urandom;
                model_xfer(d[0], 1'b1, a, 3'd2, wd, er, ew, ir, erd);
                xfer(d[0], 1'b1, a, 3'd2, wd, rd, rc, wt);
                check("init_resp", rc, er);
            end
            for (int n = 0; n < 50; n++) begin
                logic [31:0] a, wd;
                logic [2:0]  sz;
                bit          wr, ir;
                int          er, ew;
                logic [31:0] erd;
                wr = 1'($urandom_range(0, 1));
                sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
                a  = ($urandom_range(0, 9) == 0) ? 32'h400 + 32'($urandom_range(0, 63))
                                                 : 32'h100 + 32'($urandom_range(0, 63));
                wd = $urandom;
                model_xfer(d[0], wr, a, sz, wd, er, ew, ir, erd);
                xfer(d[0], wr, a, sz, wd, rd, rc, wt);
                check($sformatf("rnd_d%0d_%0d_resp", d, n), rc, er);
                check($sformatf("rnd_d%0d_%0d_waits", d, n), wt, ew);
                if (ir) begin
                    check($sformatf("rnd_d%0d_%0d_rdata", d, n), rd, erd);
                    last_rd[d] = erd;
                    last_ok[d] = 1'b1;
                end else if (last_ok[d]) begin
                    check($sformatf("rnd_d%0d_%0d_hold", d, n), rd, last_rd[d]);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
